// File: rtl/speaker_command_tx.sv
`default_nettype none
// ============================================================================
// Module      : speaker_command_tx
// Description : Transmit end of the voice-command link. Accepts a 2-bit
//               device command over valid/ready, rejects the reserved code,
//               and serializes legal codes as start / code[1] / code[0] /
//               even parity / stop, followed by an idle-high gap. Counts
//               completed frames with an 8-bit wrapping counter.
// Revision    : 1.0 - initial release
// ============================================================================
module speaker_command_tx #(
    parameter int BIT_CYCLES = 16,
    parameter int GAP_BITS   = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    input  logic [1:0] cmd_code,
    output logic       cmd_ready,
    output logic       tx_line,
    output logic       busy,
    output logic       cmd_reject,
    output logic [7:0] frames_sent
);

    localparam int CW = $clog2(BIT_CYCLES);
    localparam int GW = (GAP_BITS > 1) ? $clog2(GAP_BITS) : 1;

    localparam logic [CW-1:0] c_cnt_last = CW'(BIT_CYCLES - 1);
    localparam logic [CW-1:0] c_cnt_one  = CW'(1);
    localparam logic [GW-1:0] c_gap_last = GW'((GAP_BITS > 0) ? (GAP_BITS - 1) : 0);
    localparam logic [GW-1:0] c_gap_one  = GW'(1);
    localparam logic          c_has_gap  = (GAP_BITS > 0);
    localparam logic [1:0]    c_reserved = 2'b01;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA1  = 3'd2,
        S_DATA0  = 3'd3,
        S_PARITY = 3'd4,
        S_STOP   = 3'd5,
        S_GAP    = 3'd6
    } state_t;

    state_t          r_state;
    logic [1:0]      r_code;
    logic [CW-1:0]   r_cnt;
    logic [GW-1:0]   r_gap_cnt;
    logic            w_bit_end;

    assign w_bit_end = (r_cnt == c_cnt_last);
    assign cmd_ready = (r_state == S_IDLE);

    // Frame sequencer: every state holds for BIT_CYCLES cycles, tx_line and
    // busy are registered alongside the state so they change together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_code      <= 2'b00;
            r_cnt       <= '0;
            r_gap_cnt   <= '0;
            tx_line     <= 1'b1;
            busy        <= 1'b0;
            cmd_reject  <= 1'b0;
            frames_sent <= 8'd0;
        end else begin
            cmd_reject <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        if (cmd_code == c_reserved) begin
                            cmd_reject <= 1'b1;
                        end else begin
                            r_code  <= cmd_code;
                            r_state <= S_START;
                            r_cnt   <= '0;
                            tx_line <= 1'b0;
                            busy    <= 1'b1;
                        end
                    end
                end
                S_START: begin
                    if (w_bit_end) begin
                        r_state <= S_DATA1;
                        r_cnt   <= '0;
                        tx_line <= r_code[1];
                    end else begin
                        r_cnt <= r_cnt + c_cnt_one;
                    end
                end
                S_DATA1: begin
                    if (w_bit_end) begin
                        r_state <= S_DATA0;
                        r_cnt   <= '0;
                        tx_line <= r_code[0];
                    end else begin
                        r_cnt <= r_cnt + c_cnt_one;
                    end
                end
                S_DATA0: begin
                    if (w_bit_end) begin
                        r_state <= S_PARITY;
                        r_cnt   <= '0;
                        tx_line <= r_code[1] ^ r_code[0];
                    end else begin
                        r_cnt <= r_cnt + c_cnt_one;
                    end
                end
                S_PARITY: begin
                    if (w_bit_end) begin
                        r_state <= S_STOP;
                        r_cnt   <= '0;
                        tx_line <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + c_cnt_one;
                    end
                end
                S_STOP: begin
                    if (w_bit_end) begin
                        r_cnt       <= '0;
                        frames_sent <= frames_sent + 8'd1;
                        if (c_has_gap) begin
                            r_state   <= S_GAP;
                            r_gap_cnt <= '0;
                        end else begin
                            r_state <= S_IDLE;
                            busy    <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt + c_cnt_one;
                    end
                end
                S_GAP: begin
                    if (w_bit_end) begin
                        r_cnt <= '0;
                        if (r_gap_cnt == c_gap_last) begin
                            r_state <= S_IDLE;
                            busy    <= 1'b0;
                        end else begin
                            r_gap_cnt <= r_gap_cnt + c_gap_one;
                        end
                    end else begin
                        r_cnt <= r_cnt + c_cnt_one;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                    tx_line <= 1'b1;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
